// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES-128 round types, S-box and column helpers.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    // Index 0 is the most significant byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        aes_byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_pipe_if
// Brief    : Input/output valid-ready beat bundle of the AES round engine.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_round_pipe_if #(
    parameter int TAG_W = 8
);
    import aes_pkg::*;

    logic             in_valid;
    logic             in_ready;
    aes_state_t       in_data;
    aes_state_t       in_key;
    logic             in_last;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    aes_state_t       out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_key, in_last, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_key, in_last, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/aes_mix_columns.sv
`default_nettype none
// ============================================================================
// Module   : aes_mix_columns
// Brief    : Combinational 128-bit MixColumns; bypass_i passes the state through.
// Revision : 1.0 - initial release
// ============================================================================
module aes_mix_columns
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    input  logic       bypass_i,
    output aes_state_t state_o
);

    aes_state_t mixed;

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        assign mixed[127 - 32*gc -: 32] = mix_column(state_i[127 - 32*gc -: 32]);
    end

    assign state_o = bypass_i ? state_i : mixed;

endmodule
`default_nettype wire

// File: rtl/aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_pipe
// Brief    : Back-pressurable AES-128 encryption round, 1..4 register stages.
//            Optional stall counter enabled by AES_ROUND_PIPE_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_pipe
    import aes_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    aes_round_pipe_if.slave     bus,
    output logic                busy
`ifdef AES_ROUND_PIPE_STALL_CNT_EN
  , output logic [31:0]         stall_cnt
`endif
);

    // Register slots: 0 input, 1 after SubBytes, 2 after MixColumns, 3 output.
    localparam logic [3:0] STAGE_MASK = (STAGES <= 1) ? 4'b1000 :
                                        (STAGES == 2) ? 4'b1010 :
                                        (STAGES == 3) ? 4'b1011 : 4'b1111;

    typedef struct packed {
        aes_state_t       data;
        aes_state_t       key;
        logic             last;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t [3:0] beat_q, beat_d;
    logic  [3:0] vld_q, vld_d, take;
    beat_t       in_beat, s0_beat, sb_beat, s1_beat, mc_beat, s2_beat, ark_beat;
    logic        s0_vld, s1_vld, s2_vld;
    aes_state_t  sub_data, mc_data;
    logic        unused_ok;

    // A slot can load whenever some present slot at or after it is empty,
    // which is what lets bubbles collapse while out_ready is low.
    always_comb begin
        take = '0;
        for (int p = 0; p < 4; p++) begin
            take[p] = bus.out_ready | (|(~vld_q & STAGE_MASK & (4'hF << p)));
        end
    end

    assign in_beat = {bus.in_data, bus.in_key, bus.in_last, bus.in_tag};
    assign s0_beat = STAGE_MASK[0] ? beat_q[0] : in_beat;
    assign s0_vld  = STAGE_MASK[0] ? vld_q[0]  : bus.in_valid;

    always_comb begin
        sub_data = '0;
        for (int i = 0; i < 16; i++) begin
            sub_data[8*i +: 8] = SBOX[s0_beat.data[8*i +: 8]];
        end
    end

    always_comb begin
        sb_beat      = s0_beat;
        sb_beat.data = shift_rows(sub_data);
    end

    assign s1_beat = STAGE_MASK[1] ? beat_q[1] : sb_beat;
    assign s1_vld  = STAGE_MASK[1] ? vld_q[1]  : s0_vld;

    aes_mix_columns u_mix (
        .state_i  (s1_beat.data),
        .bypass_i (s1_beat.last),
        .state_o  (mc_data)
    );

    always_comb begin
        mc_beat      = s1_beat;
        mc_beat.data = mc_data;
    end

    assign s2_beat = STAGE_MASK[2] ? beat_q[2] : mc_beat;
    assign s2_vld  = STAGE_MASK[2] ? vld_q[2]  : s1_vld;

    always_comb begin
        ark_beat      = s2_beat;
        ark_beat.data = s2_beat.data ^ s2_beat.key;
    end

    // Absent slots never load, so their registers stay at reset value.
    always_comb begin
        vld_d  = vld_q;
        beat_d = beat_q;
        if (STAGE_MASK[0] && take[0]) begin
            vld_d[0]  = bus.in_valid;
            beat_d[0] = in_beat;
        end
        if (STAGE_MASK[1] && take[1]) begin
            vld_d[1]  = s0_vld;
            beat_d[1] = sb_beat;
        end
        if (STAGE_MASK[2] && take[2]) begin
            vld_d[2]  = s1_vld;
            beat_d[2] = mc_beat;
        end
        if (take[3]) begin
            vld_d[3]  = s2_vld;
            beat_d[3] = ark_beat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= '0;
            beat_q <= '0;
        end else begin
            vld_q  <= vld_d;
            beat_q <= beat_d;
        end
    end

    assign bus.in_ready  = take[0];
    assign bus.out_valid = vld_q[3];
    assign bus.out_data  = beat_q[3].data;
    assign bus.out_tag   = beat_q[3].tag;
    assign busy          = |vld_q;
    assign unused_ok     = ^{beat_q[3].key, beat_q[3].last};

`ifdef AES_ROUND_PIPE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (vld_q[3] && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_pipe
// Brief    : Directed bench driving STAGES=1..4 instances from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_pipe;
    import aes_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic [7:0]   in_tag = '0;

    logic         ov [1:4];
    logic         ir [1:4];
    logic         bz [1:4];
    logic [127:0] od [1:4];
    logic [7:0]   ot [1:4];
`ifdef AES_ROUND_PIPE_STALL_CNT_EN
    logic [31:0]  sc [1:4];
`endif

    vec_t tbl [8];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    for (genvar gs = 1; gs <= 4; gs++) begin : g_dut
        aes_round_pipe_if #(.TAG_W(8)) u_bus ();

        assign u_bus.in_valid  = in_valid;
        assign u_bus.in_data   = in_data;
        assign u_bus.in_key    = in_key;
        assign u_bus.in_last   = in_last;
        assign u_bus.in_tag    = in_tag;
        assign u_bus.out_ready = out_ready;
        assign ov[gs] = u_bus.out_valid;
        assign ir[gs] = u_bus.in_ready;
        assign od[gs] = u_bus.out_data;
        assign ot[gs] = u_bus.out_tag;

        aes_round_pipe #(.STAGES(gs), .TAG_W(8)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .bus       (u_bus.slave),
            .busy      (bz[gs])
`ifdef AES_ROUND_PIPE_STALL_CNT_EN
          , .stall_cnt (sc[gs])
`endif
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic drive(input logic v, input int idx, input logic [7:0] tag);
        in_valid = v;
        in_data  = tbl[idx].data;
        in_key   = tbl[idx].key;
        in_last  = tbl[idx].last;
        in_tag   = tag;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); #1;
        for (int s = 1; s <= 4; s++) begin
            chk($sformatf("rst_s%0d_out_valid", s), 128'(ov[s]), 128'd0);
            chk($sformatf("rst_s%0d_busy", s), 128'(bz[s]), 128'd0);
            chk($sformatf("rst_s%0d_out_data", s), od[s], 128'd0);
            chk($sformatf("rst_s%0d_out_tag", s), 128'(ot[s]), 128'd0);
`ifdef AES_ROUND_PIPE_STALL_CNT_EN
            chk($sformatf("rst_s%0d_stall_cnt", s), 128'(sc[s]), 128'd0);
`endif
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        for (int s = 1; s <= 4; s++) chk($sformatf("rst_s%0d_in_ready", s), 128'(ir[s]), 128'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, got;
        bit saw_full;

        tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'ha0fafe1788542cb123a339392a6c7605,
                   1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049};
        tbl[1] = '{128'ha49c7ff2689f352b6b5bea43026a5049, 128'hf2c295f27a96b9435935807a7359f67f,
                   1'b0, 128'haa8f5f0361dde3ef82d24ad26832469a};
        tbl[2] = '{128'haa8f5f0361dde3ef82d24ad26832469a, 128'h3d80477d4716fe3e1e237e446d7a883b,
                   1'b0, 128'h486c4eee671d9d0d4de3b138d65f58e7};
        tbl[3] = '{128'heb40f21e592e38848ba113e71bc342d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                   1'b1, 128'h3925841d02dc09fbdc118597196a0b32};
        tbl[4] = '{128'h0, 128'h0, 1'b0, {16{8'h63}}};
        tbl[5] = '{128'h0, {16{8'hff}}, 1'b1, {16{8'h9c}}};
        tbl[6] = '{{16{8'h01}}, 128'h0, 1'b0, {16{8'h7c}}};
        tbl[7] = '{{16{8'h01}}, 128'h00112233445566778899aabbccddeeff,
                   1'b1, 128'h7c6d5e4f38291a0bf4e5d6c7b0a19283};

        // Continuous stream into every STAGES variant.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c < 8) drive(1'b1, c, 8'(c + 'h5A));
            else       in_valid = 1'b0;
            #1;
            for (int s = 1; s <= 4; s++) begin
                if (c < 8) chk($sformatf("sweep_s%0d_c%0d_in_ready", s, c), 128'(ir[s]), 128'd1);
                chk($sformatf("sweep_s%0d_c%0d_out_valid", s, c), 128'(ov[s]),
                    128'((c >= s) && (c < s + 8)));
                if ((c >= s) && (c < s + 8) && ov[s]) begin
                    chk($sformatf("sweep_s%0d_c%0d_data", s, c), od[s], tbl[c - s].exp);
                    chk($sformatf("sweep_s%0d_c%0d_tag", s, c), 128'(ot[s]), 128'(c - s + 'h5A));
                end
            end
        end

        // Back-pressure on STAGES=3: out_ready low for cycles 4..9.
        do_reset();
        sent = 0; got = 0; saw_full = 1'b0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 9);
            if (sent < 10) drive(1'b1, sent % 8, 8'(sent));
            else           in_valid = 1'b0;
            #1;
            chk($sformatf("bp_c%0d_in_ready", c), 128'(ir[3]), 128'(out_ready || (sent - got) < 3));
            if (ov[3]) begin
                chk($sformatf("bp_c%0d_tag", c), 128'(ot[3]), 128'(got));
                chk($sformatf("bp_c%0d_data", c), od[3], tbl[got % 8].exp);
                if (out_ready) got++;
            end
            if (!ir[3]) saw_full = 1'b1;
            if (in_valid && ir[3]) sent++;
        end
        chk("bp_all_beats_out", 128'(got), 128'd10);
        chk("bp_pipe_filled", 128'(saw_full), 128'd1);
`ifdef AES_ROUND_PIPE_STALL_CNT_EN
        chk("bp_stall_cnt", 128'(sc[3]), 128'd6);
`endif

        // Bubble collapse on STAGES=4 with out_ready held low.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = (c == 6) || (c >= 8);
            if (c == 0)      drive(1'b1, 0, 8'hA0);
            else if (c == 2) drive(1'b1, 3, 8'hA1);
            else             in_valid = 1'b0;
            #1;
            if (c >= 1 && c <= 5) chk($sformatf("bub_c%0d_in_ready", c), 128'(ir[4]), 128'd1);
            if (c == 5 || c == 6) begin
                chk($sformatf("bub_c%0d_valid", c), 128'(ov[4]), 128'd1);
                chk($sformatf("bub_c%0d_tag", c), 128'(ot[4]), 128'hA0);
                chk($sformatf("bub_c%0d_data", c), od[4], tbl[0].exp);
            end
            if (c == 7 || c == 8) begin
                chk($sformatf("bub_c%0d_valid", c), 128'(ov[4]), 128'd1);
                chk($sformatf("bub_c%0d_tag", c), 128'(ot[4]), 128'hA1);
                chk($sformatf("bub_c%0d_data", c), od[4], tbl[3].exp);
            end
            if (c == 9) chk("bub_drained_busy", 128'(bz[4]), 128'd0);
        end

        // Asynchronous reset with two beats in flight on STAGES=2.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (c < 2) drive(1'b1, c + 1, 8'(8'hB0 + c));
            else       in_valid = 1'b0;
            #1;
        end
        chk("rmf_busy_before", 128'(bz[2]), 128'd1);
        chk("rmf_valid_before", 128'(ov[2]), 128'd1);
        #1 reset = 1'b0;
        #1;
        chk("rmf_valid_async", 128'(ov[2]), 128'd0);
        chk("rmf_busy_async", 128'(bz[2]), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rmf_after_c%0d_valid", c), 128'(ov[2]), 128'd0);
            chk($sformatf("rmf_after_c%0d_busy", c), 128'(bz[2]), 128'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
